// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter: FSM states and the
// eight-letter pattern/length ROM (A..H), patterns left-aligned to 16 bits.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } morse_state_t;

    localparam int SYM_W = 3;
    localparam int ROM_W = 16;

    // 1 = unit on; the unused tail of each entry is zero.
    localparam logic [ROM_W-1:0] PAT_ROM [0:7] = '{
        16'b1011_1000_0000_0000,   // A  .-
        16'b1110_1010_1000_0000,   // B  -...
        16'b1110_1011_1010_0000,   // C  -.-.
        16'b1110_1010_0000_0000,   // D  -..
        16'b1000_0000_0000_0000,   // E  .
        16'b1010_1110_1000_0000,   // F  ..-.
        16'b1110_1110_1000_0000,   // G  --.
        16'b1010_1010_0000_0000    // H  ....
    };

    localparam logic [3:0] LEN_ROM [0:7] = '{
        4'd5, 4'd9, 4'd11, 4'd7, 4'd1, 4'd9, 4'd9, 4'd7
    };

endpackage

// File: rtl/morse_tick_gen.sv
// Unit-rate generator: reloadable down-counter that emits a one-cycle tick
// each time it reaches zero while enabled, then reloads the latched period.
module morse_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] r_reload;

    assign o_tick = i_en && (r_count == {DIV_W{1'b0}});

    // Period latch and countdown; the tick cycle itself reloads the counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_count  <= {DIV_W{1'b0}};
            r_reload <= {DIV_W{1'b0}};
        end else if (i_load) begin
            r_count  <= i_load_val;
            r_reload <= i_load_val;
        end else if (i_en) begin
            if (r_count == {DIV_W{1'b0}}) begin
                r_count <= r_reload;
            end else begin
                r_count <= r_count - {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/morse_tx.sv
// Morse letter transmitter: serialises a ROM pattern MSB-first at a runtime
// unit rate, then holds the line low for GAP_UNITS units. Optional letter
// repetition is compiled in with MORSE_TX_REPEAT_EN (adds port repeat_en).
module morse_tx
    import morse_pkg::*;
#(
    parameter int PAT_W     = 16,
    parameter int DIV_W     = 8,
    parameter int GAP_UNITS = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [SYM_W-1:0] sym_sel,
    input  logic [DIV_W-1:0] tick_div,
    input  logic             start,
    input  logic             abort,
`ifdef MORSE_TX_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_MAX = (PAT_W > GAP_UNITS) ? PAT_W : GAP_UNITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_GAP = CNT_W'(GAP_UNITS);

    generate
        if (PAT_W < 11) begin : g_pat_w_check
            $error("morse_tx: PAT_W must be at least 11");
        end
        if (GAP_UNITS < 1) begin : g_gap_check
            $error("morse_tx: GAP_UNITS must be at least 1");
        end
    endgenerate

    morse_state_t     r_state;
    logic [PAT_W-1:0] r_shift;
    logic [CNT_W-1:0] r_bits;
    logic [PAT_W-1:0] w_pat;
    logic [CNT_W-1:0] w_len;
    logic             w_load;
    logic             w_tick;
`ifdef MORSE_TX_REPEAT_EN
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_len;
`endif

    // Take the top PAT_W bits of the 16-bit ROM entry, zero-padding when wider.
    assign w_pat  = PAT_W'({PAT_ROM[sym_sel], {PAT_W{1'b0}}} >> ROM_W);
    assign w_len  = CNT_W'(LEN_ROM[sym_sel]);
    assign w_load = (r_state == ST_IDLE) && start;

    morse_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clock      (clock),
        .resetn     (resetn),
        .i_load     (w_load),
        .i_load_val (tick_div),
        .i_en       (r_state != ST_IDLE),
        .o_tick     (w_tick)
    );

    // Letter FSM; out/busy/done are registered alongside the state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_shift <= {PAT_W{1'b0}};
            r_bits  <= {CNT_W{1'b0}};
            out     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef MORSE_TX_REPEAT_EN
            r_pat   <= {PAT_W{1'b0}};
            r_len   <= {CNT_W{1'b0}};
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    out  <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        r_shift <= w_pat;
                        r_bits  <= w_len;
                        out     <= w_pat[PAT_W-1];
                        busy    <= 1'b1;
                        r_state <= ST_SEND;
`ifdef MORSE_TX_REPEAT_EN
                        r_pat   <= w_pat;
                        r_len   <= w_len;
`endif
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        out     <= 1'b0;
                        busy    <= 1'b0;
                    end else if (w_tick) begin
                        r_shift <= r_shift << 1;
                        if (r_bits == C_ONE) begin
                            r_bits  <= C_GAP;
                            out     <= 1'b0;
                            r_state <= ST_GAP;
                        end else begin
                            r_bits <= r_bits - C_ONE;
                            out    <= r_shift[PAT_W-2];
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        out     <= 1'b0;
                        busy    <= 1'b0;
                    end else if (w_tick) begin
                        if (r_bits == C_ONE) begin
                            done <= 1'b1;
`ifdef MORSE_TX_REPEAT_EN
                            if (repeat_en) begin
                                r_shift <= r_pat;
                                r_bits  <= r_len;
                                out     <= r_pat[PAT_W-1];
                                r_state <= ST_SEND;
                            end else begin
                                busy    <= 1'b0;
                                r_state <= ST_IDLE;
                            end
`else
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
`endif
                        end else begin
                            r_bits <= r_bits - C_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    out     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx: expected waveforms are built from the
// dot/dash spelling of each letter (dot=1 unit, dash=3, 1-unit spaces).
module tb_morse_tx;

    localparam int GAP = 3;

    logic       clock;
    logic       resetn;
    logic [2:0] sym_sel;
    logic [7:0] tick_div;
    logic       start;
    logic       abort;
    logic       out;
    logic       busy;
    logic       done;
`ifdef MORSE_TX_REPEAT_EN
    logic       repeat_en;
`endif

    int    total = 0;
    int    bad   = 0;
    string morse [8];
    bit    units [$];

    morse_tx #(
        .PAT_W     (16),
        .DIV_W     (8),
        .GAP_UNITS (GAP)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .sym_sel  (sym_sel),
        .tick_div (tick_div),
        .start    (start),
        .abort    (abort),
`ifdef MORSE_TX_REPEAT_EN
        .repeat_en(repeat_en),
`endif
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the on/off unit sequence of a letter from its Morse spelling.
    function automatic int build_units(input int sym);
        string code;
        units.delete();
        code = morse[sym];
        for (int i = 0; i < code.len(); i++) begin
            if (i > 0) units.push_back(1'b0);
            if (code[i] == 8'h2D) begin
                units.push_back(1'b1);
                units.push_back(1'b1);
                units.push_back(1'b1);
            end else begin
                units.push_back(1'b1);
            end
        end
        return units.size();
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " out"},  {31'd0, out},  32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
    endtask

    // Sends one letter and checks every cycle against the model.
    // abort_cyc: 0 none, -1 random, >0 fixed; poke_cyc: cycle of a stray start with sym_sel=E.
    task automatic run_letter(input int sym, input int td, input int abort_cyc,
                              input int poke_cyc, input bit noise);
        int len, u, t_busy, ab, idx;
        bit exp_out;
        len    = build_units(sym);
        u      = td + 1;
        t_busy = (len + GAP) * u;
        ab     = (abort_cyc < 0) ? $urandom_range(1, t_busy) : abort_cyc;
        sym_sel  = 3'(sym);
        tick_div = 8'(td);
        start    = 1'b1;
        abort    = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c <= t_busy + 1; c++) begin
            idx     = (c - 1) / u;
            exp_out = (c <= t_busy && idx < len) ? units[idx] : 1'b0;
            chk($sformatf("s%0d td%0d c%0d out", sym, td, c),  {31'd0, out},  {31'd0, exp_out});
            chk($sformatf("s%0d td%0d c%0d busy", sym, td, c), {31'd0, busy}, {31'd0, (c <= t_busy)});
            chk($sformatf("s%0d td%0d c%0d done", sym, td, c), {31'd0, done}, {31'd0, (c == t_busy + 1)});
            if (c == ab) begin
                abort = 1'b1;
                start = 1'b0;
                step();
                abort = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    chk_idle($sformatf("abort s%0d c%0d+%0d", sym, c, k));
                    step();
                end
                return;
            end
            if (noise && c <= t_busy) begin
                start    = 1'($urandom_range(0, 1));
                sym_sel  = 3'($urandom_range(0, 7));
                tick_div = 8'($urandom_range(0, 255));
            end else if (c == poke_cyc) begin
                start   = 1'b1;
                sym_sel = 3'd4;
            end else begin
                start = 1'b0;
            end
            if (c <= t_busy) step();
        end
        start = 1'b0;
    endtask

    initial begin
        morse[0] = ".-";   morse[1] = "-...";
        morse[2] = "-.-."; morse[3] = "-..";
        morse[4] = ".";    morse[5] = "..-.";
        morse[6] = "--.";  morse[7] = "....";
        resetn = 1'b0; sym_sel = 3'd0; tick_div = 8'd0; start = 1'b0; abort = 1'b0;
`ifdef MORSE_TX_REPEAT_EN
        repeat_en = 1'b0;
`endif
        step();
        step();
        chk_idle("reset");
        #3 resetn = 1'b1;
        step();
        chk_idle("post reset");

        // Asynchronous reset in the middle of letter C.
        sym_sel = 3'd2; tick_div = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        chk("mid C busy", {31'd0, busy}, 32'd1);
        #2 resetn = 1'b0;
        #1 chk_idle("async reset");
        step();
        #2 resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_idle($sformatf("after reset %0d", k));
        end

        run_letter(0, 0, 0, 0, 1'b0);          // A at full rate
        run_letter(4, 2, 0, 0, 1'b0);          // E, 3-clock units
        run_letter(2, 1, 0, 6, 1'b0);          // C with stray start mid-letter
        run_letter(1, 0, 5, 0, 1'b0);          // B aborted in SEND
        run_letter(1, 0, 0, 0, 1'b0);          // B again, clean
        run_letter(6, 1, 20, 0, 1'b0);         // G aborted in GAP
        run_letter(4, 255, 0, 0, 1'b0);        // slowest rate
        run_letter(3, 0, 0, 0, 1'b0);          // back-to-back: accepted at done edge
        run_letter(5, 0, 0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            run_letter($urandom_range(0, 7), $urandom_range(0, 4),
                       ($urandom_range(0, 3) == 0) ? -1 : 0, 0, 1'($urandom_range(0, 1)));
        end
        step();
        chk_idle("final idle");

`ifdef MORSE_TX_REPEAT_EN
        // H repeated at full rate: 1010101000 with done every 10 clocks.
        void'(build_units(7));
        repeat_en = 1'b1; sym_sel = 3'd7; tick_div = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            chk($sformatf("rep c%0d out", c),  {31'd0, out},
                {31'd0, ((c - 1) % 10 < 7 && c <= 30) ? units[(c - 1) % 10] : 1'b0});
            chk($sformatf("rep c%0d done", c), {31'd0, done}, {31'd0, (c > 1 && (c - 1) % 10 == 0)});
            chk($sformatf("rep c%0d busy", c), {31'd0, busy}, {31'd0, (c <= 30)});
            if (c == 25) repeat_en = 1'b0;
            step();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
